// File: rtl/error_reader_if.sv
// Error memory reader bus: start/done handshake, error memory read port
// and the accumulated results. The reader owns the slave side; the
// controller / memory / consumer side uses master.
interface error_reader_if #(
   parameter int DATA_W = 20,
   parameter int ADDR_W = 8,
   parameter int ACC_W  = 48
);
   logic              start;
   logic [DATA_W-1:0] err_rdata;
   logic              e_read;
   logic [ADDR_W-1:0] e_addr;
   logic              busy;
   logic              done;
   logic [ACC_W-1:0]  sum_err;
   logic [ACC_W-1:0]  sum_sq;

   modport slave (
      input  start, err_rdata,
      output e_read, e_addr, busy, done, sum_err, sum_sq
   );

   modport master (
      output start, err_rdata,
      input  e_read, e_addr, busy, done, sum_err, sum_sq
   );
endinterface

// File: rtl/error_reader.sv
// error_reader: streams N signed error words out of the error memory
// (synchronous read, one cycle latency) and accumulates the signed error
// sum and the sum of squared errors for the gradient/MSE stage.
//
// Build option: define ERROR_READER_SQ_EN to build the squarer and the
// sum_sq accumulator. Without it no multiplier exists and sum_sq is 0;
// sum_err, timing and handshake are unchanged.
//
// Pass timing: READ for N cycles, DRAIN one cycle (last word lands),
// DONE one cycle (done pulse), then IDLE. Both accumulators wrap
// modulo 2^ACC_W.
module error_reader #(
   parameter int N      = 150,
   parameter int DATA_W = 20,
   parameter int ADDR_W = 8,
   parameter int ACC_W  = 48
) (
   input  logic          clk_i,
   input  logic          rst_i,
   error_reader_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Address of the final word; the counter parks here after a pass so
   // e_addr never goes past N-1.
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic              vld_q;
   logic              rd;
   logic              clr;
   logic [ACC_W-1:0]  sum_err_q, sum_err_d;

   // Read word seen as signed, then sign-extended (or wrapped) to ACC_W.
   logic signed [DATA_W-1:0] rd_s;
   logic signed [ACC_W-1:0]  err_acc;

   assign rd_s    = bus.err_rdata;
   assign err_acc = ACC_W'(rd_s);

   // Next-state, counter and strobe decode.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rd      = 1'b0;
      clr     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d = READ;
               cnt_d   = '0;
               clr     = 1'b1;
            end
         end
         READ: begin
            rd = 1'b1;
            if (cnt_q == LAST_ADDR) begin
               state_d = DRAIN;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DRAIN:   state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Signed error accumulator: cleared on a new pass, adds each returned word.
   always_comb begin
      sum_err_d = sum_err_q;
      if (clr) begin
         sum_err_d = '0;
      end else if (vld_q) begin
         sum_err_d = sum_err_q + err_acc;
      end
   end

   // State, counter, read-valid pipe and error sum registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         vld_q     <= 1'b0;
         sum_err_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         vld_q     <= rd;
         sum_err_q <= sum_err_d;
      end
   end

`ifdef ERROR_READER_SQ_EN
   // Square is computed at full 2*DATA_W width so -2^(DATA_W-1) squares to
   // 2^(2*DATA_W-2) without overflow; it is non-negative, so zero-extend.
   logic signed [2*DATA_W-1:0] rd_w;
   logic signed [2*DATA_W-1:0] sq;
   logic        [2*DATA_W-1:0] sq_u;
   logic        [ACC_W-1:0]    sq_acc;
   logic        [ACC_W-1:0]    sum_sq_q, sum_sq_d;

   assign rd_w   = (2*DATA_W)'(rd_s);
   assign sq     = rd_w * rd_w;
   assign sq_u   = sq;
   assign sq_acc = ACC_W'(sq_u);

   // Squared error accumulator, same clear/enable as the signed sum.
   always_comb begin
      sum_sq_d = sum_sq_q;
      if (clr) begin
         sum_sq_d = '0;
      end else if (vld_q) begin
         sum_sq_d = sum_sq_q + sq_acc;
      end
   end

   // Squared error sum register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sum_sq_q <= '0;
      end else begin
         sum_sq_q <= sum_sq_d;
      end
   end

   assign bus.sum_sq = sum_sq_q;
`else
   assign bus.sum_sq = '0;
`endif

   assign bus.e_read  = rd;
   assign bus.e_addr  = cnt_q;
   assign bus.busy    = (state_q != IDLE);
   assign bus.done    = (state_q == DONE);
   assign bus.sum_err = sum_err_q;

endmodule

// File: tb/tb_error_reader.sv
// Directed bench for error_reader. Three instances:
//   a: N=4, memory {3,-2,5,-1}      -> sum_err 5, sum_sq 39
//   b: N=2, memory {-2^19,-2^19}    -> sum_err -1048576, sum_sq 2^39
//   c: N=2, DATA_W=8, ACC_W=8, {100,100} -> sum_err 0xC8, sum_sq 20000 mod 256 = 32
// sum_sq expectations are 0 when ERROR_READER_SQ_EN is not defined.
module tb_error_reader;

`ifdef ERROR_READER_SQ_EN
   localparam logic [63:0] SQ_A = 64'd39;
   localparam logic [63:0] SQ_B = 64'd549755813888;
   localparam logic [63:0] SQ_C = 64'd32;
`else
   localparam logic [63:0] SQ_A = 64'd0;
   localparam logic [63:0] SQ_B = 64'd0;
   localparam logic [63:0] SQ_C = 64'd0;
`endif

   bit   clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   error_reader_if #(.DATA_W(20), .ADDR_W(8), .ACC_W(48)) ifa ();
   error_reader_if #(.DATA_W(20), .ADDR_W(8), .ACC_W(48)) ifb ();
   error_reader_if #(.DATA_W(8),  .ADDR_W(2), .ACC_W(8))  ifc ();

   error_reader #(.N(4), .DATA_W(20), .ADDR_W(8), .ACC_W(48)) u_a (
      .clk_i(clk), .rst_i(rst), .bus(ifa));
   error_reader #(.N(2), .DATA_W(20), .ADDR_W(8), .ACC_W(48)) u_b (
      .clk_i(clk), .rst_i(rst), .bus(ifb));
   error_reader #(.N(2), .DATA_W(8), .ADDR_W(2), .ACC_W(8)) u_c (
      .clk_i(clk), .rst_i(rst), .bus(ifc));

   logic [19:0] mem_a [4] = '{20'd3, 20'hFFFFE, 20'd5, 20'hFFFFF};

   // Error memories: synchronous read, data one cycle after e_read.
   always @(posedge clk) begin
      if (rst) begin
         ifa.err_rdata <= '0;
         ifb.err_rdata <= '0;
         ifc.err_rdata <= '0;
      end else begin
         if (ifa.e_read) ifa.err_rdata <= mem_a[ifa.e_addr[1:0]];
         if (ifb.e_read) ifb.err_rdata <= 20'h80000;
         if (ifc.e_read) ifc.err_rdata <= 8'd100;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Call in cycle 1 of a pass (right after the start edge). Walks 7 cycles
   // (N+3 for N=4), recording addresses, done pulses and sums at done.
   task automatic observe_a(input bit hold, input bit poke,
                            output int done_at, output int ndone, output int nrd,
                            output bit addr_ok, output logic [47:0] se,
                            output logic [47:0] ss);
      done_at = 0; ndone = 0; nrd = 0; addr_ok = 1'b1; se = '0; ss = '0;
      for (int c = 1; c <= 7; c++) begin
         if (ifa.e_read) begin
            if (ifa.e_addr != 8'(nrd)) addr_ok = 1'b0;
            nrd++;
         end
         if (ifa.done) begin
            ndone++;
            if (done_at == 0) done_at = c;
            se = ifa.sum_err;
            ss = ifa.sum_sq;
         end
         ifa.start = hold | (poke & ((c == 2) || (c == 5)));
         tick();
      end
      ifa.start = 1'b0;
   endtask

   int          d_at, nd, nr, cnt;
   bit          aok, got;
   logic [47:0] se, ss;

   initial begin
      rst = 1'b1;
      ifa.start = 1'b0; ifb.start = 1'b0; ifc.start = 1'b0;
      tick(); tick();
      chk("rst_e_read",  64'(ifa.e_read),  64'd0);
      chk("rst_e_addr",  64'(ifa.e_addr),  64'd0);
      chk("rst_busy",    64'(ifa.busy),    64'd0);
      chk("rst_done",    64'(ifa.done),    64'd0);
      chk("rst_sum_err", 64'(ifa.sum_err), 64'd0);
      chk("rst_sum_sq",  64'(ifa.sum_sq),  64'd0);
      rst = 1'b0;
      tick();

      // Nominal pass
      ifa.start = 1'b1; tick(); ifa.start = 1'b0;
      observe_a(1'b0, 1'b0, d_at, nd, nr, aok, se, ss);
      chk("nom_done_cycle", 64'(d_at), 64'd6);
      chk("nom_done_count", 64'(nd),   64'd1);
      chk("nom_reads",      64'(nr),   64'd4);
      chk("nom_addr_seq",   64'(aok),  64'd1);
      chk("nom_sum_err",    64'(se),   64'd5);
      chk("nom_sum_sq",     64'(ss),   SQ_A);
      chk("nom_hold_err",   64'(ifa.sum_err), 64'd5);
      chk("nom_hold_sq",    64'(ifa.sum_sq),  SQ_A);
      chk("nom_idle_busy",  64'(ifa.busy),    64'd0);
      chk("nom_addr_park",  64'(ifa.e_addr),  64'd3);

      // Back-to-back: start held through DONE restarts from IDLE
      ifa.start = 1'b1; tick();
      observe_a(1'b1, 1'b0, d_at, nd, nr, aok, se, ss);
      chk("b2b_done_cycle", 64'(d_at), 64'd6);
      chk("b2b_sum_err1",   64'(se),   64'd5);
      chk("b2b_sum_sq1",    64'(ss),   SQ_A);
      chk("b2b_restart_rd", 64'(ifa.e_read),  64'd1);
      chk("b2b_restart_ad", 64'(ifa.e_addr),  64'd0);
      chk("b2b_cleared",    64'(ifa.sum_err), 64'd0);
      observe_a(1'b0, 1'b0, d_at, nd, nr, aok, se, ss);
      chk("b2b_done_cycle2", 64'(d_at), 64'd6);
      chk("b2b_sum_err2",    64'(se),   64'd5);
      chk("b2b_sum_sq2",     64'(ss),   SQ_A);

      // Reset during the third READ cycle
      ifa.start = 1'b1; tick(); ifa.start = 1'b0;
      tick(); tick();
      chk("mid_addr_before", 64'(ifa.e_addr), 64'd2);
      rst = 1'b1; tick(); rst = 1'b0;
      chk("mid_e_read",  64'(ifa.e_read),  64'd0);
      chk("mid_busy",    64'(ifa.busy),    64'd0);
      chk("mid_done",    64'(ifa.done),    64'd0);
      chk("mid_sum_err", 64'(ifa.sum_err), 64'd0);
      chk("mid_sum_sq",  64'(ifa.sum_sq),  64'd0);
      chk("mid_e_addr",  64'(ifa.e_addr),  64'd0);
      cnt = 0;
      for (int i = 0; i < 6; i++) begin
         if (ifa.done) cnt++;
         tick();
      end
      chk("mid_no_done", 64'(cnt), 64'd0);
      ifa.start = 1'b1; tick(); ifa.start = 1'b0;
      observe_a(1'b0, 1'b0, d_at, nd, nr, aok, se, ss);
      chk("mid_fresh_err", 64'(se), 64'd5);
      chk("mid_fresh_sq",  64'(ss), SQ_A);

      // start pulsed during READ and DRAIN is ignored
      ifa.start = 1'b1; tick(); ifa.start = 1'b0;
      observe_a(1'b0, 1'b1, d_at, nd, nr, aok, se, ss);
      chk("ign_done_count", 64'(nd),   64'd1);
      chk("ign_done_cycle", 64'(d_at), 64'd6);
      chk("ign_reads",      64'(nr),   64'd4);
      chk("ign_addr_seq",   64'(aok),  64'd1);
      chk("ign_sum_err",    64'(se),   64'd5);

      // Extremes: N=2, both words -2^19
      ifb.start = 1'b1; tick(); ifb.start = 1'b0;
      got = 1'b0; d_at = 0;
      for (int c = 1; c <= 20 && !got; c++) begin
         if (ifb.done) begin
            got = 1'b1; d_at = c; se = ifb.sum_err; ss = ifb.sum_sq;
         end else begin
            tick();
         end
      end
      chk("ext_done_seen",  64'(got),  64'd1);
      chk("ext_done_cycle", 64'(d_at), 64'd4);
      chk("ext_sum_err",    64'(se),   64'hFFFF_FFF0_0000);
      chk("ext_sum_sq",     64'(ss),   SQ_B);

      // Wrap: ACC_W=8, 100+100 -> 0xC8
      ifc.start = 1'b1; tick(); ifc.start = 1'b0;
      got = 1'b0;
      for (int c = 1; c <= 20 && !got; c++) begin
         if (ifc.done) begin
            got = 1'b1; se = 48'(ifc.sum_err); ss = 48'(ifc.sum_sq);
         end else begin
            tick();
         end
      end
      chk("wrap_done_seen", 64'(got), 64'd1);
      chk("wrap_sum_err",   64'(se),  64'hC8);
      chk("wrap_sum_sq",    64'(ss),  SQ_C);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
